// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types for the code-to-bitmap decoder
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_ACC    = 1'b1
    } mode_t;

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - combinational binary-code to one-hot decoder
module dec_onehot #(
    parameter int IN_WIDTH = 6
) (
    input  logic [IN_WIDTH-1:0]      code,
    output logic [(2**IN_WIDTH)-1:0] onehot
);

    // Single set bit at the position named by the code; every code is legal.
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/dec_bitmap.sv
// rtl/dec_bitmap.sv - windowed one-hot/bitmap decoder; DEC_BITMAP_DUP_EN enables duplicate-code flag
module dec_bitmap
    import dec_pkg::*;
#(
    parameter int   IN_WIDTH  = 6,
    parameter logic OUT_REG   = 1'b1,
    localparam int  OUT_WIDTH = 2**IN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 init_i,
    input  logic                 mode_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 done_o,
    output logic [IN_WIDTH:0]    cnt_o,
    output logic                 dup_o
);

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_eff;
    logic [OUT_WIDTH-1:0]   onehot, acc_q, acc_d, acc_base, v;
    logic [IN_WIDTH:0]      cnt_q, cnt_d, cnt_base;
    logic                   start, sample, done_s;

    dec_onehot #(.IN_WIDTH(IN_WIDTH)) u_onehot (
        .code   (data_i),
        .onehot (onehot)
    );

    // Window FSM: start from IDLE or DONE, DONE lasts one cycle and drives done_s.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_i) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!init_i) state_d = DONE;
            end
            DONE: begin
                done_s = 1'b1;
                if (init_i) begin
                    start   = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: a start edge both clears the window and samples its first code.
    always_comb begin
        sample   = start || ((state_q == RUN) && init_i);
        mode_eff = start ? mode_t'(mode_i) : mode_q;
        acc_base = start ? '0 : acc_q;
        cnt_base = start ? '0 : cnt_q;
        acc_d    = sample ? (acc_base | onehot) : acc_q;
        if (sample) begin
            cnt_d = (&cnt_base) ? cnt_base : cnt_base + {{IN_WIDTH{1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        if (sample) begin
            v = (mode_eff == MODE_ACC) ? (acc_base | onehot) : onehot;
        end else begin
            v = (mode_q == MODE_ACC) ? acc_q : '0;
        end
    end

    // Core state: FSM, latched mode, accumulated bitmap and window count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONEHOT;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (start) mode_q <= mode_t'(mode_i);
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            // Registered output stage, one cycle behind the internal values.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_o <= '0;
                    done_o <= 1'b0;
                    cnt_o  <= '0;
                end else begin
                    data_o <= v;
                    done_o <= done_s;
                    cnt_o  <= cnt_d;
                end
            end
        end else begin : g_out_comb
            // Direct outputs are masked so they read zero while reset is held.
            assign data_o = rst_n_i ? v : '0;
            assign done_o = rst_n_i & done_s;
            assign cnt_o  = rst_n_i ? cnt_d : '0;
        end
    endgenerate

`ifdef DEC_BITMAP_DUP_EN
    logic dup_q, dup_d;

    // Sticky flag: a sampled code landing on a bit already set this window.
    always_comb begin
        dup_d = dup_q;
        if (start) begin
            dup_d = 1'b0;
        end else if (sample && |(acc_q & onehot)) begin
            dup_d = 1'b1;
        end
    end

    // Duplicate flag register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) dup_q <= 1'b0;
        else          dup_q <= dup_d;
    end

    generate
        if (OUT_REG) begin : g_dup_reg
            // Registered copy aligned with the other outputs.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) dup_o <= 1'b0;
                else          dup_o <= dup_d;
            end
        end else begin : g_dup_comb
            assign dup_o = rst_n_i & dup_d;
        end
    endgenerate
`else
    assign dup_o = 1'b0;
`endif

endmodule

// File: tb/tb_dec_bitmap.sv
// tb/tb_dec_bitmap.sv - directed table and sequence checks for dec_bitmap
module tb_dec_bitmap;

`ifdef DEC_BITMAP_DUP_EN
    localparam logic DUP_ON = 1'b1;
`else
    localparam logic DUP_ON = 1'b0;
`endif

    typedef struct {
        logic        init;
        logic        mode;
        logic [7:0]  code;
        logic [63:0] dat;
        logic        done;
        logic [6:0]  cnt;
        logic        dup;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, init, mode;
    logic [7:0] code;

    logic [63:0] d6_data;
    logic        d6_done, d6_dup;
    logic [6:0]  d6_cnt;
    logic [7:0]  d3_data;
    logic        d3_done, d3_dup;
    logic [3:0]  d3_cnt;
    logic [3:0]  d2_data;
    logic        d2_done, d2_dup;
    logic [2:0]  d2_cnt;

    logic [7:0]  c3_data;
    logic        c3_done, c3_dup;
    logic [3:0]  c3_cnt;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[19];

    dec_bitmap #(.IN_WIDTH(6), .OUT_REG(1'b1)) u_dut6 (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .mode_i(mode), .data_i(code[5:0]),
        .data_o(d6_data), .done_o(d6_done), .cnt_o(d6_cnt), .dup_o(d6_dup)
    );

    dec_bitmap #(.IN_WIDTH(3), .OUT_REG(1'b0)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .mode_i(mode), .data_i(code[2:0]),
        .data_o(d3_data), .done_o(d3_done), .cnt_o(d3_cnt), .dup_o(d3_dup)
    );

    dec_bitmap #(.IN_WIDTH(2), .OUT_REG(1'b1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .mode_i(mode), .data_i(code[1:0]),
        .data_o(d2_data), .done_o(d2_done), .cnt_o(d2_cnt), .dup_o(d2_dup)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, snapshot the direct-output DUT, return at posedge+1.
    task automatic step(input logic i, input logic m, input logic [7:0] d);
        init = i;
        mode = m;
        code = d;
        @(negedge clk);
        c3_data = d3_data;
        c3_done = d3_done;
        c3_cnt  = d3_cnt;
        c3_dup  = d3_dup;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'd3,  64'h28 & 64'h08, 1'b0, 7'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'd5,  64'h28, 1'b0, 7'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'd3,  64'h28, 1'b0, 7'd3, DUP_ON};
        tbl[3]  = '{1'b0, 1'b0, 8'd0,  64'h28, 1'b0, 7'd3, DUP_ON};
        tbl[4]  = '{1'b0, 1'b0, 8'd0,  64'h28, 1'b1, 7'd3, DUP_ON};
        tbl[5]  = '{1'b0, 1'b0, 8'd0,  64'h28, 1'b0, 7'd3, DUP_ON};
        tbl[6]  = '{1'b1, 1'b1, 8'd1,  64'h02, 1'b0, 7'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'd4,  64'h12, 1'b0, 7'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'd0,  64'h12, 1'b0, 7'd2, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'd2,  64'h04, 1'b1, 7'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'd2,  64'h04, 1'b0, 7'd2, DUP_ON};
        tbl[11] = '{1'b1, 1'b1, 8'd7,  64'h80, 1'b0, 7'd3, DUP_ON};
        tbl[12] = '{1'b0, 1'b0, 8'd0,  64'h00, 1'b0, 7'd3, DUP_ON};
        tbl[13] = '{1'b0, 1'b0, 8'd0,  64'h00, 1'b1, 7'd3, DUP_ON};
        tbl[14] = '{1'b0, 1'b0, 8'd0,  64'h00, 1'b0, 7'd3, DUP_ON};
        tbl[15] = '{1'b1, 1'b1, 8'd63, 64'h8000_0000_0000_0000, 1'b0, 7'd1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'd0,  64'h8000_0000_0000_0000, 1'b0, 7'd1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'd0,  64'h8000_0000_0000_0000, 1'b1, 7'd1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 8'd0,  64'h8000_0000_0000_0000, 1'b0, 7'd1, 1'b0};

        rst_n = 1'b1;
        init  = 1'b0;
        mode  = 1'b0;
        code  = 8'd0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_d6_data", d6_data, 64'h0);
        chk("rst_d6_done", {63'd0, d6_done}, 64'h0);
        chk("rst_d6_cnt", {57'd0, d6_cnt}, 64'h0);
        chk("rst_d6_dup", {63'd0, d6_dup}, 64'h0);
        chk("rst_d3_data", {56'd0, d3_data}, 64'h0);
        chk("rst_d3_cnt", {60'd0, d3_cnt}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: mode-1 accumulate with repeat, back-to-back windows, length-1 window.
        for (int k = 0; k < 19; k++) begin
            step(tbl[k].init, tbl[k].mode, tbl[k].code);
            chk($sformatf("tbl%0d_data", k), d6_data, tbl[k].dat);
            chk($sformatf("tbl%0d_done", k), {63'd0, d6_done}, {63'd0, tbl[k].done});
            chk($sformatf("tbl%0d_cnt", k), {57'd0, d6_cnt}, {57'd0, tbl[k].cnt});
            chk($sformatf("tbl%0d_dup", k), {63'd0, d6_dup}, {63'd0, tbl[k].dup});
        end

        // Full one-hot sweep on the 6-bit registered instance.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk($sformatf("sweep%0d", i), d6_data, 64'd1 << i);
        end
        step(1'b0, 1'b0, 8'd0);
        chk("sweep_cnt", {57'd0, d6_cnt}, 64'd64);
        chk("sweep_done_early", {63'd0, d6_done}, 64'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("sweep_done_pulse", {63'd0, d6_done}, 64'd1);
        step(1'b0, 1'b0, 8'd0);
        chk("sweep_done_end", {63'd0, d6_done}, 64'd0);

        // Direct-output 3-bit instance accumulates every code.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(i));
        chk("acc3_data", {56'd0, c3_data}, 64'hFF);
        chk("acc3_cnt", {60'd0, c3_cnt}, 64'd8);
        chk("acc3_dup", {63'd0, c3_dup}, 64'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("acc3_fall_done", {63'd0, c3_done}, 64'd0);
        step(1'b0, 1'b0, 8'd0);
        chk("acc3_done", {63'd0, c3_done}, 64'd1);
        chk("acc3_done_data", {56'd0, c3_data}, 64'hFF);
        step(1'b0, 1'b0, 8'd0);
        chk("acc3_hold_data", {56'd0, c3_data}, 64'hFF);
        chk("acc3_hold_done", {63'd0, c3_done}, 64'd0);

        // 2-bit instance: count saturates at 7.
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1, 8'(k % 4));
            chk($sformatf("sat_cnt%0d", k), {61'd0, d2_cnt}, (k + 1 > 7) ? 64'd7 : 64'(k + 1));
        end
        chk("sat_dup", {63'd0, d2_dup}, {63'd0, DUP_ON});
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'd0);

        // Reset mid-window with init still high.
        step(1'b1, 1'b1, 8'd5);
        step(1'b1, 1'b1, 8'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_d6_data", d6_data, 64'h0);
        chk("mrst_d6_cnt", {57'd0, d6_cnt}, 64'h0);
        chk("mrst_d6_done", {63'd0, d6_done}, 64'h0);
        chk("mrst_d6_dup", {63'd0, d6_dup}, 64'h0);
        chk("mrst_d3_data", {56'd0, d3_data}, 64'h0);
        chk("mrst_d3_cnt", {60'd0, d3_cnt}, 64'h0);
        chk("mrst_d3_done", {63'd0, d3_done}, 64'h0);
        chk("mrst_d2_cnt", {61'd0, d2_cnt}, 64'h0);
        init = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 8'd0);
            chk($sformatf("post_rst_d6_done%0d", k), {63'd0, d6_done}, 64'd0);
            chk($sformatf("post_rst_d3_done%0d", k), {63'd0, c3_done}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
